// File: rtl/weight_ram_loader.sv
// Streams NUM_WORDS weight bytes into the weight block RAM through port A, can read
// the region back to compare sums, then pulses done so the downstream controllers may start.
module weight_ram_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7,
  parameter int NUM_WORDS = 64,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] LAST  = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] COUNT = CW'(NUM_WORDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic              verify_q;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     rcnt;
  logic [CW-1:0]     acnt;
  logic [15:0]       rb_sum;
  logic [RD_LAT-1:0] vld_sr;
  logic              hs;
  logic              issue;
  logic              tag;

  assign wr_ready = (state == S_WRITE);
  assign hs       = wr_ready & wr_valid;
  assign issue    = (state == S_VERIFY) && (rcnt != COUNT);
  // The tap at depth RD_LAT lines up with ram_dout for the address issued RD_LAT cycles ago.
  assign tag      = vld_sr[RD_LAT-1];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state)
      S_WRITE: begin
        ram_en   = hs;
        ram_we   = hs;
        ram_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(wcnt);
        ram_din  = wr_data;
      end
      S_VERIFY: begin
        ram_en = issue;
        if (issue) ram_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rcnt);
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      verify_q <= 1'b0;
      wcnt     <= '0;
      rcnt     <= '0;
      acnt     <= '0;
      rb_sum   <= '0;
      vld_sr   <= '0;
      error    <= 1'b0;
      checksum <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WRITE;
            verify_q <= verify_en;
            error    <= 1'b0;
            checksum <= '0;
            wcnt     <= '0;
            rcnt     <= '0;
            acnt     <= '0;
            rb_sum   <= '0;
            vld_sr   <= '0;
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
            error <= 1'b1;
          end else if (hs) begin
            wcnt     <= wcnt + 1'b1;
            checksum <= checksum + 16'(wr_data);
            if (wcnt == LAST) state <= verify_q ? S_VERIFY : S_DONE;
          end
        end
        S_VERIFY: begin
          if (abort) begin
            state <= S_IDLE;
            error <= 1'b1;
          end else begin
            if (issue) rcnt <= rcnt + 1'b1;
            if (tag) begin
              rb_sum <= rb_sum + 16'(ram_dout);
              acnt   <= acnt + 1'b1;
              if (acnt == LAST) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          state <= abort ? S_IDLE : S_DONE;
          error <= abort ? 1'b1 : (rb_sum != checksum);
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_ram_loader.sv
// Self-checking bench for weight_ram_loader: a cycle-timeline model derived from the load
// rules is compared against the DUT every cycle, plus literal checks per scenario.
module tb_weight_ram_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int N      = 64;
  localparam int BASE   = 0;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, verify_en, abort, wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready, ram_en, ram_we, busy, done, error;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic [15:0]       checksum;

  weight_ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(N),
                      .BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .verify_en(verify_en), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .ram_en(ram_en),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM with RD_LAT-cycle read pipeline; optional corruption of the word read from address 5.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic [ADDR_W-1:0] ad_pipe [RD_LAT];
  logic              corrupt = 1'b0;
  int                write_cnt = 0;

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_din;
      write_cnt++;
    end
    rd_pipe[0] <= mem[ram_addr];
    ad_pipe[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      ad_pipe[i] <= ad_pipe[i-1];
    end
  end

  assign ram_dout = rd_pipe[RD_LAT-1] +
                    ((corrupt && ad_pipe[RD_LAT-1] == 7'd5) ? 8'd1 : 8'd0);

  // Timeline model: a load is "handshakes so far" then "cycles since the last handshake".
  bit          m_act = 0, m_ver = 0, m_err = 0, m_bad = 0;
  int          m_hs = 0, m_after = 0;
  logic [15:0] m_sum = '0;
  int          cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;

  always @(negedge clk) begin
    logic              e_rdy, e_en, e_we, e_busy, e_done, cmp_ad;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    bit                in_done;
    cyc++;
    e_rdy = 0; e_en = 0; e_we = 0; e_busy = 0; e_done = 0;
    e_addr = '0; e_din = '0; cmp_ad = 1;
    if (!reset) begin
      m_act = 0; m_err = 0; m_sum = '0;
    end else if (m_act) begin
      e_busy = 1;
      cmp_ad = 0;
      if (m_hs < N) begin
        e_rdy = 1; e_en = wr_valid; e_we = wr_valid;
        e_addr = ADDR_W'(BASE + m_hs); e_din = wr_data; cmp_ad = 1;
      end else if (!m_ver) begin
        e_done = (m_after == 1);
      end else begin
        if (m_after <= N) begin
          e_en = 1; e_addr = ADDR_W'(BASE + m_after - 1); cmp_ad = 1;
        end
        e_done = (m_after == N + RD_LAT + 2);
      end
    end
    check("cycle_ctl", {10'd0, wr_ready, ram_en, ram_we, busy, done, error, checksum},
          {10'd0, e_rdy, e_en, e_we, e_busy, e_done, m_err, m_sum});
    if (cmp_ad) check("cycle_addr_data", {17'd0, ram_addr, ram_din}, {17'd0, e_addr, e_din});
    if (reset && done) begin
      done_cnt++;
      done_cyc = cyc;
    end

    if (reset) begin
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_hs = 0; m_after = 0; m_ver = verify_en; m_sum = '0; m_err = 0;
          m_bad = verify_en && corrupt;
          start_cyc = cyc;
        end
      end else begin
        in_done = (m_hs == N) && (m_after == (m_ver ? N + RD_LAT + 2 : 1));
        if (in_done) m_act = 0;
        else if (abort) begin
          m_act = 0; m_err = 1;
        end else if (m_hs < N) begin
          if (wr_valid) begin
            m_sum += 16'(wr_data);
            m_hs++;
            if (m_hs == N) m_after = 1;
          end
        end else begin
          if (m_ver && m_after == N + RD_LAT + 1) m_err = m_bad;
          m_after++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic ver);
    start = 1'b1; verify_en = ver;
    tick();
    start = 1'b0; verify_en = 1'b0;
  endtask

  // mode 0: back-to-back data=beat index; 1: valid toggling, data 0xFF; 2: random.
  task automatic stream(input int mode, input int beats);
    int sent = 0;
    for (int k = 0; k < 20 * N && sent < beats; k++) begin
      case (mode)
        0:       begin wr_valid = 1'b1; wr_data = DATA_W'(sent); end
        1:       begin wr_valid = (k % 2 == 0); wr_data = 8'hFF; end
        default: begin wr_valid = 1'($urandom_range(0, 1)); wr_data = 8'($urandom); end
      endcase
      tick();
      if (wr_valid) sent++;
    end
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000 && busy; k++) tick();
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] mism;
    int          d0, w0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    reset = 1'b0; start = 0; verify_en = 0; abort = 0; wr_valid = 0; wr_data = '0;
    repeat (3) tick();
    check("reset_state", {error, busy, done, wr_ready, ram_en, ram_we, checksum}, 32'd0);
    reset = 1'b1;
    tick();

    // Plain write of 0..63.
    d0 = done_cnt;
    start_load(1'b0);
    stream(0, N);
    wait_idle();
    check("t1_checksum", {16'd0, checksum}, 32'h07E0);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    mism = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== 8'(i)) mism++;
    check("t1_ram_contents", mism, 32'd0);

    // Write + verify, correct RAM.
    start_load(1'b1);
    stream(0, N);
    wait_idle();
    check("t2_checksum", {16'd0, checksum}, 32'h07E0);
    check("t2_error", {31'd0, error}, 32'd0);
    check("t2_latency", done_cyc - start_cyc, 32'(64 + 64 + RD_LAT + 2));

    // Write + verify with corrupted readback at address 5.
    corrupt = 1'b1;
    d0 = done_cnt;
    start_load(1'b1);
    stream(0, N);
    wait_idle();
    corrupt = 1'b0;
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_done_pulses", done_cnt - d0, 32'd1);

    // Gapped stream of 0xFF.
    w0 = write_cnt;
    start_load(1'b0);
    stream(1, N);
    wait_idle();
    check("t4_checksum", {16'd0, checksum}, 32'h3FC0);
    check("t4_writes", write_cnt - w0, 32'd64);

    // Asynchronous reset mid-write, then a clean reload.
    start_load(1'b0);
    stream(0, 10);
    #2 reset = 1'b0;
    #1 check("t5_async_reset", {error, busy, done, wr_ready, ram_en, ram_we, checksum}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    start_load(1'b0);
    stream(0, N);
    wait_idle();
    check("t5_checksum", {16'd0, checksum}, 32'h07E0);

    // Start ignored mid-write, abort at beat 20.
    d0 = done_cnt;
    start_load(1'b0);
    stream(2, 10);
    start = 1'b1; verify_en = 1'b1; tick(); start = 1'b0; verify_en = 1'b0;
    stream(2, 10);
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (3) tick();
    check("t6_error", {31'd0, error}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_no_done", done_cnt - d0, 32'd0);

    // Abort during readback, with start and abort together in IDLE (start wins).
    d0 = done_cnt;
    start = 1'b1; verify_en = 1'b1; abort = 1'b1; tick();
    start = 1'b0; verify_en = 1'b0; abort = 1'b0;
    stream(0, N);
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    check("t7_error", {31'd0, error}, 32'd1);
    check("t7_no_done", done_cnt - d0, 32'd0);

    // Random loads; the per-cycle model does the checking.
    for (int r = 0; r < 4; r++) begin
      corrupt = 1'($urandom_range(0, 1));
      start_load(1'($urandom_range(0, 1)));
      stream(2, N);
      wait_idle();
      corrupt = 1'b0;
    end
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
